// File: rtl/adc_pipe_phase_ctrl.sv
// adc_pipe_phase_ctrl
//
// Conversion sequencer for the 3-bit pipelined ADC. It generates the two
// non-overlapping sample/amplify phases (phi1/phi2) from the system clock, and
// holds the pipe encoder in reset while idle. It runs a requested number of
// conversions plus the pipeline flush, and returns each encoder result through
// a start/busy/valid/done handshake.
//
// Phase sequence: IDLE -> PH1 -> GAP1 -> PH2 -> GAP2 -> PH1 ...
// One phi period is 2*(PHASE_CYC+GAP_CYC) clk cycles. The encoder output is
// captured on the last GAP2 cycle of every period from index LATENCY onward.
//
// Optional feature macro: ADC_PIPE_CONT_EN
//   When it is defined, a start with num_conv_i == 0 selects continuous mode.
//   Periods then run until en_i drops or reset_i is asserted, with one valid_o
//   per period and no done_o. When it is undefined, a zero count gives a single
//   done_o pulse and runs no phases.
//
// Parameters:
//   PHASE_CYC  clk cycles each phase is high (>= 1)
//   GAP_CYC    clk cycles both phases are low between phases (>= 1)
//   LATENCY    phi periods from sample to valid encoder output
//   CNT_W      width of the conversion-count request
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous reset, active-high
//   en_i         sequencer enable; low aborts to IDLE
//   start_i      start request, sampled only in IDLE
//   num_conv_i   conversions to perform, latched on start
//   d_i          encoder output
//   phi1_o       sample phase
//   phi2_o       amplify/hold phase
//   enc_reset_o  encoder reset, high while idle
//   busy_o       sequence in progress
//   valid_o      one-cycle pulse, data_o holds a new result
//   data_o       captured conversion result
//   done_o       one-cycle pulse, sequence finished

module adc_pipe_phase_ctrl #(
    parameter int unsigned PHASE_CYC = 4,
    parameter int unsigned GAP_CYC   = 1,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_conv_i,
    input  logic [2:0]       d_i,
    output logic             phi1_o,
    output logic             phi2_o,
    output logic             enc_reset_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [2:0]       data_o,
    output logic             done_o
);

    localparam int unsigned MAX_CYC = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
    localparam int unsigned PC_W    = $clog2(MAX_CYC + 1);
    localparam int unsigned P_W     = CNT_W + 2;

    localparam logic [PC_W-1:0] PH_LAST  = PC_W'(PHASE_CYC - 1);
    localparam logic [PC_W-1:0] GAP_LAST = PC_W'(GAP_CYC - 1);
    localparam logic [P_W-1:0]  LAT_P    = P_W'(LATENCY);

`ifdef ADC_PIPE_CONT_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StPh1,
        StGap1,
        StPh2,
        StGap2
    } state_e;

    state_e           state_q;
    logic [PC_W-1:0]  phase_cnt_q;  // cycles spent in the current phase state
    logic [P_W-1:0]   per_q;        // 0-based phi period index
    logic [CNT_W-1:0] n_q;          // latched conversion count
    logic             cont_q;       // continuous mode selected at start
    logic [P_W-1:0]   last_per;     // index of the final period of a counted run

    // The counted run covers N + LATENCY periods, so the last index is N + LATENCY - 1.
    assign last_per = {2'b00, n_q} + LAT_P - P_W'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            phase_cnt_q <= '0;
            per_q       <= '0;
            n_q         <= '0;
            cont_q      <= 1'b0;
            phi1_o      <= 1'b0;
            phi2_o      <= 1'b0;
            enc_reset_o <= 1'b1;
            busy_o      <= 1'b0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            done_o      <= 1'b0;
        end else begin
            // Pulse outputs default low; the branches below raise them for one cycle.
            valid_o <= 1'b0;
            done_o  <= 1'b0;

            if ((state_q != StIdle) && !en_i) begin
                // Abort: both phases drop together, so no runt overlap can occur.
                // data_o keeps the last captured result.
                state_q     <= StIdle;
                phase_cnt_q <= '0;
                per_q       <= '0;
                cont_q      <= 1'b0;
                phi1_o      <= 1'b0;
                phi2_o      <= 1'b0;
                busy_o      <= 1'b0;
                enc_reset_o <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i && en_i) begin
                            if ((num_conv_i != '0) || CONT_EN) begin
                                state_q     <= StPh1;
                                phase_cnt_q <= '0;
                                per_q       <= '0;
                                n_q         <= num_conv_i;
                                cont_q      <= (num_conv_i == '0);
                                phi1_o      <= 1'b1;
                                busy_o      <= 1'b1;
                                enc_reset_o <= 1'b0;
                            end else begin
                                // Zero-count request completes immediately.
                                done_o <= 1'b1;
                            end
                        end
                    end

                    StPh1: begin
                        if (phase_cnt_q == PH_LAST) begin
                            state_q     <= StGap1;
                            phase_cnt_q <= '0;
                            phi1_o      <= 1'b0;
                        end else begin
                            phase_cnt_q <= phase_cnt_q + 1'b1;
                        end
                    end

                    StGap1: begin
                        if (phase_cnt_q == GAP_LAST) begin
                            state_q     <= StPh2;
                            phase_cnt_q <= '0;
                            phi2_o      <= 1'b1;
                        end else begin
                            phase_cnt_q <= phase_cnt_q + 1'b1;
                        end
                    end

                    StPh2: begin
                        if (phase_cnt_q == PH_LAST) begin
                            state_q     <= StGap2;
                            phase_cnt_q <= '0;
                            phi2_o      <= 1'b0;
                        end else begin
                            phase_cnt_q <= phase_cnt_q + 1'b1;
                        end
                    end

                    StGap2: begin
                        if (phase_cnt_q == GAP_LAST) begin
                            phase_cnt_q <= '0;
                            // Periods before LATENCY only fill the pipeline.
                            if (per_q >= LAT_P) begin
                                data_o  <= d_i;
                                valid_o <= 1'b1;
                            end
                            if (!cont_q && (per_q == last_per)) begin
                                state_q     <= StIdle;
                                per_q       <= '0;
                                busy_o      <= 1'b0;
                                enc_reset_o <= 1'b1;
                                done_o      <= 1'b1;
                            end else begin
                                state_q <= StPh1;
                                phi1_o  <= 1'b1;
                                // In continuous mode the index parks at LATENCY,
                                // so the counter never wraps.
                                if (!cont_q || (per_q < LAT_P)) begin
                                    per_q <= per_q + 1'b1;
                                end
                            end
                        end else begin
                            phase_cnt_q <= phase_cnt_q + 1'b1;
                        end
                    end

                    default: begin
                        state_q     <= StIdle;
                        phase_cnt_q <= '0;
                        per_q       <= '0;
                        cont_q      <= 1'b0;
                        phi1_o      <= 1'b0;
                        phi2_o      <= 1'b0;
                        busy_o      <= 1'b0;
                        enc_reset_o <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
